// File: rtl/iir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iir_pkg : shared encodings and helpers for the IIR SOS sequencer     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package iir_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    typedef enum int {
        OVF_F0 = 0,
        OVF_F1 = 1,
        OVF_B0 = 2,
        OVF_B1 = 3
    } ovf_bit_e;

    localparam int OVF_W = int'(OVF_B1) + 1;

    // 1.0 in integer units; shifted left by the fraction width where used
    localparam int UNITY_SCALE = 1;

    function automatic int sec_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iir_scale_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iir_scale_regfile : per-section scale coefficients, sync write,      |
// | async read, reset to unity. Rev 1.0                                  |
// +----------------------------------------------------------------------+
module iir_scale_regfile
    import iir_pkg::*;
#(
    parameter int             NUMBER      = 4,
    parameter int             SW          = sec_width(NUMBER),
    parameter int             DW          = 16,
    parameter logic [DW-1:0]  RESET_VALUE = '0
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          we,
    input  logic [SW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [SW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_regs [NUMBER];

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUMBER; i++) begin
                r_regs[i] <= RESET_VALUE;
            end
        end else if (we && (32'(waddr) < NUMBER)) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign rdata = (32'(raddr) < NUMBER) ? r_regs[raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/iir_sos_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iir_sos_sequencer : runs NUMBER sections on one shared SOS engine    |
// | per input sample, collects sticky overflow flags. Rev 1.0            |
// +----------------------------------------------------------------------+
module iir_sos_sequencer
    import iir_pkg::*;
#(
    parameter int NUMBER  = 4,
    parameter int WIS     = 5,
    parameter int WFS     = 11,
    parameter int TMO_MAX = 15,
    localparam int SW     = sec_width(NUMBER),
    localparam int DW     = WIS + WFS
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  CE,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  eng_start,
    output logic [SW-1:0]         eng_sec,
    output logic [DW-1:0]         eng_scale,
    input  logic                  eng_done,
    input  logic [OVF_W-1:0]      eng_ovf,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  cfg_we,
    input  logic [SW-1:0]         cfg_addr,
    input  logic [DW-1:0]         cfg_data,
    input  logic                  ovf_clr,
    output logic [OVF_W*NUMBER-1:0] ovf_sticky,
    output logic                  timeout
);

    localparam int            CW      = $clog2(TMO_MAX + 1);
    localparam logic [DW-1:0] C_UNITY = DW'(UNITY_SCALE) << WFS;

    logic [1:0]              r_state;
    logic [SW-1:0]           r_sec;
    logic [CW-1:0]           r_cnt;
    logic [DW-1:0]           r_scale;
    logic [OVF_W*NUMBER-1:0] r_sticky;
    logic                    r_timeout;

    logic                    w_in_idle;
    logic                    w_in_wait;
    logic                    w_done;
    logic                    w_last;
    logic [CW-1:0]           w_cnt_inc;
    logic                    w_tmo_hit;
    logic [SW-1:0]           w_next_sec;
    logic [DW-1:0]           w_rd_scale;
    logic [DW-1:0]           w_load_scale;
    logic [OVF_W*NUMBER-1:0] w_sticky_nxt;

    assign w_in_idle  = (r_state == ST_IDLE);
    assign w_in_wait  = (r_state == ST_WAIT);
    assign w_done     = CE & w_in_wait & eng_done;
    assign w_last     = (r_sec == SW'(NUMBER - 1));
    assign w_cnt_inc  = r_cnt + CW'(1);
    assign w_tmo_hit  = CE & w_in_wait & ~eng_done & (w_cnt_inc == CW'(TMO_MAX));
    assign w_next_sec = w_in_idle ? '0 : r_sec + SW'(1);

    iir_scale_regfile #(
        .NUMBER      (NUMBER),
        .SW          (SW),
        .DW          (DW),
        .RESET_VALUE (C_UNITY)
    ) u_regfile (
        .CLK   (CLK),
        .Reset (Reset),
        .we    (CE & cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (w_next_sec),
        .rdata (w_rd_scale)
    );

    // A write landing on the same edge that enters ISSUE must be seen by that run
    assign w_load_scale = (CE && cfg_we && (cfg_addr == w_next_sec)) ? cfg_data : w_rd_scale;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_sec   <= '0;
            r_cnt   <= '0;
            r_scale <= '0;
        end else if (CE) begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state <= ST_ISSUE;
                        r_sec   <= '0;
                        r_scale <= w_load_scale;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                    r_cnt   <= '0;
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        if (w_last) begin
                            r_state <= ST_OUT;
                        end else begin
                            r_state <= ST_ISSUE;
                            r_sec   <= w_next_sec;
                            r_scale <= w_load_scale;
                        end
                    end else if (w_tmo_hit) begin
                        r_state <= ST_IDLE;
                        r_sec   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The section being set this cycle survives a simultaneous clear
    always_comb begin
        w_sticky_nxt = r_sticky;
        for (int s = 0; s < NUMBER; s++) begin
            if (w_done && (r_sec == SW'(s))) begin
                w_sticky_nxt[OVF_W*s +: OVF_W] = r_sticky[OVF_W*s +: OVF_W] | eng_ovf;
            end else if (ovf_clr) begin
                w_sticky_nxt[OVF_W*s +: OVF_W] = '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_sticky  <= '0;
            r_timeout <= 1'b0;
        end else if (CE) begin
            r_sticky <= w_sticky_nxt;
            if (w_tmo_hit) begin
                r_timeout <= 1'b1;
            end else if (ovf_clr) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign in_ready   = CE & w_in_idle;
    assign eng_start  = CE & (r_state == ST_ISSUE);
    assign out_valid  = (r_state == ST_OUT);
    assign eng_sec    = r_sec;
    assign eng_scale  = r_scale;
    assign ovf_sticky = r_sticky;
    assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_iir_sos_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_iir_sos_sequencer : random stimulus, sample-level reference model |
// | and scoreboard for iir_sos_sequencer. Rev 1.0                        |
// +----------------------------------------------------------------------+
module tb_iir_sos_sequencer;

    localparam int N    = 4;
    localparam int TMO  = 15;
    localparam int NCYC = 3000;

    logic        CLK = 1'b0;
    logic        Reset, CE, in_valid, in_ready, eng_start;
    logic [1:0]  eng_sec;
    logic [15:0] eng_scale;
    logic        eng_done;
    logic [3:0]  eng_ovf;
    logic        out_valid, out_ready, cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        ovf_clr;
    logic [15:0] ovf_sticky;
    logic        timeout;

    always #5 CLK = ~CLK;

    iir_sos_sequencer dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .CE         (CE),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .eng_start  (eng_start),
        .eng_sec    (eng_sec),
        .eng_scale  (eng_scale),
        .eng_done   (eng_done),
        .eng_ovf    (eng_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky),
        .timeout    (timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: sample in flight, section index, whether the engine is working
    logic [15:0] m_scale [N];
    logic [15:0] m_sticky;
    bit          m_tmo, m_run, m_issued, m_out, clean;
    int          m_sec, m_w, eng_d;
    logic [17:0] q_start [$];
    logic [15:0] q_out [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_scale[i] = 16'h0800;
        m_sticky = '0;
        m_tmo = 0; m_run = 0; m_issued = 0; m_out = 0;
        m_sec = 0; m_w = 0;
        q_start.delete();
        q_out.delete();
    endtask

    function automatic int pick_delay();
        int r;
        if (clean) return 1;
        r = $urandom_range(0, 99);
        if (r < 75) return $urandom_range(1, 4);
        if (r < 85) return TMO;
        if (r < 93) return TMO + 1;
        return $urandom_range(5, TMO - 1);
    endfunction

    // What the next clock edge does, given the inputs of the current cycle
    task automatic model_step();
        bit start_p = 0;
        bit out_p   = 0;
        bit tmo_set = 0;
        int set_sec = -1;
        if (Reset || !CE) return;
        if (m_run && m_issued) begin
            if (eng_done) begin
                m_sticky[4*m_sec +: 4] = m_sticky[4*m_sec +: 4] | eng_ovf;
                set_sec  = m_sec;
                m_issued = 0;
                if (m_sec == N - 1) begin
                    m_run = 0; m_out = 1; out_p = 1;
                end else begin
                    m_sec++; start_p = 1;
                end
            end else begin
                m_w++;
                if (m_w == TMO) begin
                    tmo_set = 1; m_run = 0; m_issued = 0; m_sec = 0;
                end
            end
        end else if (m_run) begin
            m_issued = 1; m_w = 0; eng_d = pick_delay();
        end else if (m_out) begin
            if (out_ready) m_out = 0;
        end else if (in_valid) begin
            m_run = 1; m_sec = 0; start_p = 1;
        end
        if (cfg_we) m_scale[cfg_addr] = cfg_data;
        if (ovf_clr) begin
            for (int s = 0; s < N; s++) if (s != set_sec) m_sticky[4*s +: 4] = 4'h0;
            m_tmo = 0;
        end
        if (tmo_set) m_tmo = 1;
        if (start_p) q_start.push_back({2'(m_sec), m_scale[m_sec]});
        if (out_p) q_out.push_back(m_sticky);
    endtask

    task automatic drive();
        CE        = clean ? 1'b1 : ($urandom_range(0, 9) != 0);
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = clean ? 1'b1 : ($urandom_range(0, 9) < 6);
        cfg_we    = !clean && ($urandom_range(0, 15) == 0);
        cfg_addr  = 2'($urandom);
        cfg_data  = 16'($urandom);
        ovf_clr   = !clean && ($urandom_range(0, 31) == 0);
        eng_ovf   = 4'($urandom);
        if (m_run && m_issued && CE) eng_done = (m_w + 1 == eng_d);
        else                         eng_done = ($urandom_range(0, 7) == 0);
    endtask

    // Monitor: per-cycle output checks plus scoreboard pops on start / result events
    initial begin
        bit          prev_ov = 0;
        logic [17:0] last_start = '0;
        forever begin
            @(negedge CLK);
            chk("in_ready",   in_ready,   32'(!m_run && !m_out && CE));
            chk("out_valid",  out_valid,  32'(m_out));
            chk("ovf_sticky", ovf_sticky, m_sticky);
            chk("timeout",    timeout,    32'(m_tmo));
            chk("eng_start",  eng_start,  32'(m_run && !m_issued && CE));
            if (eng_start === 1'b1) begin
                last_start = {eng_sec, eng_scale};
                if (q_start.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL start_sb: got start sec %0d expected none at %0t", eng_sec, $time);
                end else begin
                    chk("start_sec_scale", {eng_sec, eng_scale}, q_start.pop_front());
                end
            end
            if (m_run && m_issued) chk("wait_hold", {eng_sec, eng_scale}, last_start);
            if (out_valid === 1'b1 && !prev_ov) begin
                if (q_out.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL out_sb: got out_valid expected none at %0t", $time);
                end else begin
                    chk("out_flags", ovf_sticky, q_out.pop_front());
                end
            end
            prev_ov = (out_valid === 1'b1);
        end
    end

    initial begin
        Reset = 1'b1; CE = 1'b1; in_valid = 1'b0; eng_done = 1'b0; eng_ovf = '0;
        out_ready = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; ovf_clr = 1'b0;
        clean = 1;
        model_reset();
        @(negedge CLK);
        chk("rst_eng_scale", eng_scale, 32'h0);
        chk("rst_eng_sec",   eng_sec,   32'h0);
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
        for (int cyc = 0; cyc < NCYC + 80; cyc++) begin
            clean = (cyc < 60) || (cyc >= NCYC);
            if (cyc == 1200 || cyc == 2300) begin
                Reset = 1'b1;
                model_reset();
            end else begin
                Reset = 1'b0;
            end
            drive();
            if (cyc >= NCYC) in_valid = 1'b0;
            @(negedge CLK);
            #1 model_step();
            @(posedge CLK);
            #1;
        end
        chk("start_q_drained", q_start.size(), 32'h0);
        chk("out_q_drained",   q_out.size(),   32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
